// File: rtl/multi_frac_clkdiv.sv
// Multi-channel fractional clock divider: one phase accumulator per channel produces
// a one-cycle enable on each wrap and a divided clock equal to the accumulator MSB.
module multi_frac_clkdiv #(
    parameter  int CHANNELS    = 4,
    parameter  int ACC_BITS    = 24,
    parameter  int INC_DEFAULT = 0,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_clk_src,
    input  logic                i_reset,
    input  logic [CHANNELS-1:0] i_ch_enable,
    input  logic                i_sync_clear,
    input  logic                i_cfg_we,
    input  logic [CH_W-1:0]     i_cfg_ch,
    input  logic [ACC_BITS-1:0] i_cfg_inc,
    input  logic                i_cfg_immediate,
    output logic [CHANNELS-1:0] o_clk_en,
    output logic [CHANNELS-1:0] o_clk_div,
    output logic [CHANNELS-1:0] o_cfg_pending
);

    // Half the accumulator range is the fastest rate that still yields a 50% clock.
    localparam logic [ACC_BITS-1:0] INC_MAX = ACC_BITS'(1) << (ACC_BITS - 1);
    localparam logic [ACC_BITS-1:0] INC_RST =
        (longint'(INC_DEFAULT) > (longint'(1) << (ACC_BITS - 1))) ? INC_MAX : ACC_BITS'(INC_DEFAULT);

    logic [ACC_BITS-1:0] w_inc_clamped;
    logic                w_cfg_valid;

    assign w_inc_clamped = (i_cfg_inc > INC_MAX) ? INC_MAX : i_cfg_inc;
    assign w_cfg_valid   = ({1'b0, i_cfg_ch} < (CH_W + 1)'(CHANNELS));

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [ACC_BITS-1:0] r_acc;
        logic [ACC_BITS-1:0] r_active;
        logic [ACC_BITS-1:0] r_shadow;
        logic                r_pending;
        logic                r_en;
        logic                r_div;

        logic [ACC_BITS:0]   w_sum;
        logic                w_carry;
        logic                w_wr;
        logic [ACC_BITS-1:0] w_acc_nxt;
        logic [ACC_BITS-1:0] w_active_nxt;
        logic [ACC_BITS-1:0] w_shadow_nxt;
        logic                w_pending_nxt;
        logic                w_en_nxt;
        logic                w_div_nxt;

        assign w_sum   = {1'b0, r_acc} + {1'b0, r_active};
        assign w_carry = w_sum[ACC_BITS];
        assign w_wr    = i_cfg_we && w_cfg_valid && (i_cfg_ch == CH_W'(g));

        always_comb begin
            w_acc_nxt     = r_acc;
            w_active_nxt  = r_active;
            w_shadow_nxt  = r_shadow;
            w_pending_nxt = r_pending;
            w_en_nxt      = 1'b0;
            w_div_nxt     = r_div;

            if (i_sync_clear) begin
                w_acc_nxt = '0;
                w_div_nxt = 1'b0;
                if (r_pending) begin
                    w_active_nxt  = r_shadow;
                    w_pending_nxt = 1'b0;
                end
            end else if (i_ch_enable[g]) begin
                w_acc_nxt = w_sum[ACC_BITS-1:0];
                w_en_nxt  = w_carry;
                w_div_nxt = w_sum[ACC_BITS-1];
                if (w_carry && r_pending) begin
                    w_active_nxt  = r_shadow;
                    w_pending_nxt = 1'b0;
                end
            end

            // A write lands after any shadow transfer, so a coincident deferred write stays pending.
            if (w_wr) begin
                w_shadow_nxt = w_inc_clamped;
                if (i_cfg_immediate) begin
                    w_active_nxt  = w_inc_clamped;
                    w_pending_nxt = 1'b0;
                end else begin
                    w_pending_nxt = 1'b1;
                end
            end
        end

        always_ff @(posedge i_clk_src or posedge i_reset) begin
            if (i_reset) begin
                r_acc     <= '0;
                r_active  <= INC_RST;
                r_shadow  <= INC_RST;
                r_pending <= 1'b0;
                r_en      <= 1'b0;
                r_div     <= 1'b0;
            end else begin
                r_acc     <= w_acc_nxt;
                r_active  <= w_active_nxt;
                r_shadow  <= w_shadow_nxt;
                r_pending <= w_pending_nxt;
                r_en      <= w_en_nxt;
                r_div     <= w_div_nxt;
            end
        end

        assign o_clk_en[g]      = r_en;
        assign o_clk_div[g]     = r_div;
        assign o_cfg_pending[g] = r_pending;
    end

endmodule

// File: tb/tb_multi_frac_clkdiv.sv
// Bench for multi_frac_clkdiv with 3 channels and an 8-bit accumulator.
module tb_multi_frac_clkdiv;

    localparam int NCH = 3;
    localparam int AB  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] en;
    logic           sclr;
    logic           we;
    logic [1:0]     ch;
    logic [AB-1:0]  inc;
    logic           imm;
    logic [NCH-1:0] o_en;
    logic [NCH-1:0] o_div;
    logic [NCH-1:0] o_pend;

    int n_pass = 0;
    int n_tot  = 0;

    multi_frac_clkdiv #(.CHANNELS(NCH), .ACC_BITS(AB), .INC_DEFAULT(0)) dut (
        .i_clk_src      (clk),
        .i_reset        (rst),
        .i_ch_enable    (en),
        .i_sync_clear   (sclr),
        .i_cfg_we       (we),
        .i_cfg_ch       (ch),
        .i_cfg_inc      (inc),
        .i_cfg_immediate(imm),
        .o_clk_en       (o_en),
        .o_clk_div      (o_div),
        .o_cfg_pending  (o_pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           we;
        logic [1:0]     ch;
        logic [AB-1:0]  inc;
        logic           imm;
        logic [NCH-1:0] en;
        logic [NCH-1:0] x_en;
        logic [NCH-1:0] x_div;
        logic [NCH-1:0] x_pend;
    } vec_t;

    typedef struct {
        string          nm;
        logic [NCH-1:0] mask;
        logic [NCH-1:0] x_en;
        logic [NCH-1:0] x_div;
    } exp_t;

    vec_t tv[13];
    exp_t sb[$];
    int   p85_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] c, input logic [AB-1:0] v, input logic i);
        we = 1'b1; ch = c; inc = v; imm = i;
        tick();
        we = 1'b0;
    endtask

    task automatic sb_check();
        exp_t x;
        x = sb.pop_front();
        chk({x.nm, "_en"},  32'(o_en & x.mask),  32'(x.x_en & x.mask));
        chk({x.nm, "_div"}, 32'(o_div & x.mask), 32'(x.x_div & x.mask));
    endtask

    // Ideal accumulator from the rate definition: pulse when floor(inc*k/256) steps.
    function automatic logic pulse_at(input int inc_v, input int k);
        return ((inc_v * k) / 256) != ((inc_v * (k - 1)) / 256);
    endfunction

    function automatic logic div_at(input int inc_v, input int k);
        return ((inc_v * k) % 256) >= 128;
    endfunction

    function automatic vec_t mkv(input logic w, input logic [AB-1:0] v, input logic i, input logic [NCH-1:0] e,
                                 input logic [NCH-1:0] xe, input logic [NCH-1:0] xd, input logic [NCH-1:0] xp);
        vec_t r;
        r.we = w; r.ch = 2'd0; r.inc = v; r.imm = i; r.en = e;
        r.x_en = xe; r.x_div = xd; r.x_pend = xp;
        return r;
    endfunction

    initial begin
        int last;
        int npulse;
        int gap;
        int seen_en;
        int seen_div;
        logic act;
        logic exp_now;

        // Channel 0: immediate 64 while stopped, then run; deferred 32 on edge 2.
        tv[0]  = mkv(1'b1, 8'd64, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000);
        tv[1]  = mkv(1'b0, 8'd0,  1'b0, 3'b001, 3'b000, 3'b000, 3'b000);
        tv[2]  = mkv(1'b1, 8'd32, 1'b0, 3'b001, 3'b000, 3'b001, 3'b001);
        tv[3]  = mkv(1'b0, 8'd0,  1'b0, 3'b001, 3'b000, 3'b001, 3'b001);
        tv[4]  = mkv(1'b0, 8'd0,  1'b0, 3'b001, 3'b001, 3'b000, 3'b000);
        for (int i = 5; i <= 7; i++)  tv[i] = mkv(1'b0, 8'd0, 1'b0, 3'b001, 3'b000, 3'b000, 3'b000);
        for (int i = 8; i <= 11; i++) tv[i] = mkv(1'b0, 8'd0, 1'b0, 3'b001, 3'b000, 3'b001, 3'b000);
        tv[12] = mkv(1'b0, 8'd0,  1'b0, 3'b001, 3'b001, 3'b000, 3'b000);

        rst = 1'b1; en = '0; sclr = 1'b0; we = 1'b0; ch = 2'd0; inc = '0; imm = 1'b0;
        tick(); tick();
        chk("reset_en",   32'(o_en),   32'd0);
        chk("reset_div",  32'(o_div),  32'd0);
        chk("reset_pend", 32'(o_pend), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            we = tv[i].we; ch = tv[i].ch; inc = tv[i].inc; imm = tv[i].imm; en = tv[i].en;
            tick();
            chk($sformatf("tv%0d_en", i),   32'(o_en),   32'(tv[i].x_en));
            chk($sformatf("tv%0d_div", i),  32'(o_div),  32'(tv[i].x_div));
            chk($sformatf("tv%0d_pend", i), 32'(o_pend), 32'(tv[i].x_pend));
        end
        we = 1'b0; en = '0;

        // Channel 1 at inc=85 for 256 edges: 85 pulses spaced 3 or 4 apart.
        cfg_write(2'd1, 8'd85, 1'b1);
        en = 3'b010; last = 0; npulse = 0;
        for (int k = 1; k <= 256; k++) begin
            if (pulse_at(85, k)) p85_q.push_back(k);
            tick();
            act     = o_en[1];
            exp_now = (p85_q.size() > 0) && (p85_q[0] == k);
            if (act || exp_now) begin
                chk($sformatf("p85_pulse_e%0d", k), 32'(act), 32'(exp_now));
                if (exp_now) void'(p85_q.pop_front());
            end
            if (act) begin
                gap = k - last;
                if (last > 0) chk($sformatf("p85_gap_e%0d", k), 32'(gap == 3 || gap == 4), 32'd1);
                last = k;
                npulse++;
            end
        end
        chk("p85_count", 32'(npulse), 32'd85);
        chk("p85_queue_empty", 32'(p85_q.size()), 32'd0);
        en = '0;

        // Channel 2: 200 clamps to 128, then a write of 0 freezes it with clk_div high.
        cfg_write(2'd2, 8'd200, 1'b1);
        en = 3'b100;
        for (int k = 1; k <= 19; k++) begin
            if (k <= 9) sb.push_back('{$sformatf("clamp_e%0d", k), 3'b100, {(k % 2 == 0), 2'b00}, {(k % 2 == 1), 2'b00}});
            else        sb.push_back('{$sformatf("frozen_e%0d", k), 3'b100, 3'b000, 3'b100});
            if (k == 9) begin we = 1'b1; ch = 2'd2; inc = 8'd0; imm = 1'b1; end
            tick();
            we = 1'b0;
            sb_check();
        end
        en = '0;

        // Out-of-phase channels 0 (64) and 1 (48), deferred 32 on ch1, then sync_clear.
        rst = 1'b1; tick(); rst = 1'b0;
        cfg_write(2'd0, 8'd64, 1'b1);
        cfg_write(2'd1, 8'd48, 1'b1);
        en = 3'b001; tick();
        en = 3'b011;
        for (int k = 0; k < 4; k++) tick();
        cfg_write(2'd1, 8'd32, 1'b0);
        chk("pre_clear_pend", 32'(o_pend), 32'(3'b010));
        sclr = 1'b1; tick(); sclr = 1'b0;
        chk("clear_en",   32'(o_en),   32'd0);
        chk("clear_div",  32'(o_div),  32'd0);
        chk("clear_pend", 32'(o_pend), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            sb.push_back('{$sformatf("aligned_e%0d", k), 3'b011,
                           {1'b0, pulse_at(32, k), pulse_at(64, k)},
                           {1'b0, div_at(32, k), div_at(64, k)}});
            tick();
            sb_check();
        end

        // Reset mid-period with a pending deferred write on ch0.
        cfg_write(2'd0, 8'd32, 1'b0);
        tick();
        chk("pre_reset_pend", 32'(o_pend), 32'(3'b001));
        chk("pre_reset_div",  32'(o_div),  32'(3'b011));
        #2 rst = 1'b1;
        #1;
        chk("async_reset_en",   32'(o_en),   32'd0);
        chk("async_reset_div",  32'(o_div),  32'd0);
        chk("async_reset_pend", 32'(o_pend), 32'd0);
        tick();
        rst = 1'b0; en = '0;
        // Channel 3 does not exist, so this write must leave every channel stopped.
        cfg_write(2'd3, 8'd64, 1'b1);
        en = 3'b111; seen_en = 0; seen_div = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (o_en != 3'b000)  seen_en++;
            if (o_div != 3'b000) seen_div++;
        end
        chk("post_reset_no_pulse", 32'(seen_en),  32'd0);
        chk("post_reset_div_low",  32'(seen_div), 32'd0);
        chk("post_reset_pend",     32'(o_pend),   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/multi_frac_clkdiv.md
# multi_frac_clkdiv

- Multi-channel fractional clock divider built on per-channel phase accumulators.
- Each channel produces two outputs from the fast source clock:
  - a one-cycle clock-enable pulse;
  - a near-50% divided clock.
- Every channel has a runtime-programmable increment and glitch-free deferred reconfiguration.
- Sits beside the fixed-ratio divider in the clock tree. It serves subsystems that need several audio/video/CPU rates, or rates that change at run time.

## Interface
- CHANNELS, 4: number of independent divider channels (≥1).
- ACC_BITS, 24: accumulator width; frequency resolution is f_clk / 2^ACC_BITS.
- INC_DEFAULT, 0: increment loaded into every channel at reset (0 = stopped).
- CH_W, max(1, $clog2(CHANNELS)): channel-select width (derived).

- clk_src  in  1  source clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- ch_enable  in  CHANNELS  per-channel run enable.
- sync_clear  in  1  zeroes all accumulators simultaneously (phase alignment).
- cfg_we  in  1  increment write strobe.
- cfg_ch  in  CH_W  target channel of the write.
- cfg_inc  in  ACC_BITS  new increment.
- cfg_immediate  in  1  1 = apply now, 0 = apply at the channel's next wrap.
- clk_en  out  CHANNELS  one-cycle pulse per output period.
- clk_div  out  CHANNELS  divided clock, equal to the accumulator MSB.
- cfg_pending  out  CHANNELS  a deferred increment is waiting for a wrap.

## Operation
- Per-channel state:
  - acc[ACC_BITS];
  - active inc;
  - shadow inc;
  - pending flag.
- Output frequency: f_clk_src × inc / 2^ACC_BITS.
- Increment clamp: on write, values above 2^(ACC_BITS-1) are clamped to 2^(ACC_BITS-1), which gives the maximum output of f_clk_src/2.
- Per-cycle update, in priority order:
  1. **sync_clear** (all channels): acc←0, clk_en←0, clk_div←0. A pending shadow is copied to active and pending←0.
  2. **ch_enable[i]=0**: acc and clk_div hold, clk_en←0.
  3. **Otherwise**, with sum = acc + active (ACC_BITS+1 bits):
     - acc←sum[ACC_BITS-1:0];
     - clk_en←sum[ACC_BITS];
     - clk_div←sum[ACC_BITS-1].
- inc=0 → the channel is frozen: no pulses, clk_div holds.
- Writes with cfg_ch ≥ CHANNELS are ignored.
- Immediate write: active←clamp(cfg_inc), shadow←same, pending←0. The new value is used from the next edge.
- Deferred write: shadow←clamp(cfg_inc), pending←1.
- On a carry (sum[ACC_BITS]=1) with pending=1: active←shadow, pending←0. The new increment is used from the addition after the wrap, so the period that ends in that pulse is unaltered.
- Deferred write and carry in the same cycle on the same channel:
  - the transfer uses the shadow value from before the write;
  - the written value then lands in shadow;
  - pending ends at 1.
- Writes and sync_clear in the same cycle: sync_clear takes effect first (it transfers the old shadow), then the write is applied.

## Timing
- Reset values: acc=0, active=shadow=clamp(INC_DEFAULT), pending=0, clk_en=0, clk_div=0.
- All outputs are registered. There is no combinational path from any input to any output.
- Latency:
  - clk_en is high for exactly one clk_src cycle, starting on the edge where the accumulator wraps;
  - with inc=2^ACC_BITS/N it is high on edges N, 2N, … after reset release.
- clk_div duty: exact 50% when 2^ACC_BITS/inc is an even integer. Otherwise it is within one clk_src period of 50%.
- Edge jitter on both outputs is ≤1 clk_src period; the long-term average rate is exact.
- Reset asserted mid-operation: all outputs are 0 immediately (asynchronous) and all state returns to the reset values. Counting restarts from acc=0 on the first edge after release.
- Channels are independent. sync_clear is the only cross-channel interaction.

## Test plan
- ACC_BITS=8, inc=64, ch_enable=1 → clk_en high on edges 4, 8, 12…; clk_div high after edge 2, low after edge 4, a repeating 2-high/2-low pattern.
- ACC_BITS=8, inc=85, 256 cycles → exactly 85 clk_en pulses; pulse spacing is always 3 or 4 cycles.
- ACC_BITS=8:
  - write cfg_inc=200, immediate → behaves as 128: clk_div toggles every cycle and clk_en pulses every 2 cycles.
  - write inc=0 → no further pulses and clk_div frozen.
- Active 64; deferred write of 32 at edge 2 → cfg_pending=1, next pulse still at edge 4, pending clears there, following pulses at 12, 20…
- Two channels (inc 64 and 48) running out of phase, then a sync_clear pulse → both accumulators 0 and both outputs 0 next cycle; subsequent pulses aligned to the clear edge.
- Assert reset mid-period with a pending write → outputs drop at once, cfg_pending=0, increment returns to INC_DEFAULT.
